// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pool_pkg
//  Description : Shared types and constants for the pooling-layer output
//                memory write addresser.
//                  pool_wr_state_t - write-sequencer state encoding
//                  BANKED/INTERLEAVED - channel address layout selectors
//  Revision    : 1.0 - initial release
// ============================================================================
package pool_pkg;

  // Write sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_wr_state_t;

  // Channel address layouts.
  localparam int BANKED      = 0;
  localparam int INTERLEAVED = 1;

endpackage
`default_nettype wire

// File: rtl/pool_valid_delay.sv
`default_nettype none
// ============================================================================
//  Module      : pool_valid_delay
//  Description : DEPTH-stage 1-bit shift register that delays the accept
//                strobe so each write lines up with its pooled data.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low clear of all stages
//                clr   - synchronous clear of all stages (new pass)
//                din   - strobe in
//                dout  - strobe delayed by DEPTH cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb begin
        shift_d = clr ? 1'b0 : din;
      end
    end else begin : g_chain
      always_comb begin
        shift_d = clr ? '0 : {shift_q[DEPTH-2:0], din};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign dout = shift_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pool_mem_write.sv
`default_nettype none
// ============================================================================
//  Module      : pool_mem_write
//  Description : Output-memory write addresser for a pooling layer. Accepts
//                one pooled sample set (all channels) per handshake, delays
//                the strobe by PIPE_DELAY cycles and issues one write per
//                channel with its own address (banked or interleaved).
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous active-low reset
//                start    - one-cycle pulse, begins a pass (IDLE/DONE only)
//                in_valid - pooled sample set present
//                in_ready - sample set accepted this cycle when valid
//                wr_en    - write strobe, common to all channels
//                wr_addr  - channel c address in [c*ADDR_W +: ADDR_W]
//                busy     - pass in progress (RUN or DRAIN)
//                done     - pass complete, held until next start or reset
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_mem_write
  import pool_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int CHANNELS   = 2,
  parameter int CH_DEPTH   = 72,
  parameter int BASE       = 0,
  parameter int PIPE_DELAY = 1,
  parameter int INTERLEAVE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       wr_en,
  output logic [CHANNELS*ADDR_W-1:0] wr_addr,
  output logic                       busy,
  output logic                       done
);

  localparam int               CNT_W     = $clog2(CH_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(CH_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(CH_DEPTH);

  // --------------------------------------------------------------------------
  // Elaboration-time configuration checks
  // --------------------------------------------------------------------------
  generate
    if (64'(BASE) + 64'(CHANNELS) * 64'(CH_DEPTH) - 64'd1 >= (64'd1 << ADDR_W)) begin : g_bad_range
      $fatal(1, "pool_mem_write: BASE + CHANNELS*CH_DEPTH - 1 does not fit in ADDR_W");
    end
    if (CHANNELS < 1 || CH_DEPTH < 2 || PIPE_DELAY < 1 ||
        (INTERLEAVE != BANKED && INTERLEAVE != INTERLEAVED)) begin : g_bad_param
      $fatal(1, "pool_mem_write: illegal parameter combination");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  pool_wr_state_t             state_q, state_d;
  logic [CNT_W-1:0]           acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]           wr_idx_q, wr_idx_d;
  logic [CHANNELS*ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CHANNELS*ADDR_W-1:0] idx_addr;
  logic [CNT_W-1:0]           addr_idx;
  logic                       start_ok;
  logic                       accept;
  logic                       last_wr;

  // start only takes effect when no pass is in flight.
  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign in_ready = (state_q == RUN) && (acc_cnt_q < DEPTH_CNT);
  assign accept   = in_valid && in_ready;
  assign last_wr  = wr_en && (wr_idx_q == LAST_IDX);

  // The accept strobe becomes the write strobe PIPE_DELAY cycles later. A
  // start clears the line so nothing from a previous pass leaks through.
  pool_valid_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_valid_delay (
    .clk   (clk),
    .rst_n (reset),
    .clr   (start_ok),
    .din   (accept),
    .dout  (wr_en)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && acc_cnt_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   if (last_wr) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    wr_idx_d  = wr_idx_q;
    if (start_ok) begin
      acc_cnt_d = '0;
      wr_idx_d  = '0;
    end else begin
      if (accept) begin
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end
      if (wr_en && wr_idx_q != DEPTH_CNT) begin
        wr_idx_d = wr_idx_q + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Address generation
  // --------------------------------------------------------------------------
  // After the final write the index steps to CH_DEPTH; clamping keeps the
  // held address on the last legal value instead of running past the range.
  assign addr_idx = (wr_idx_d > LAST_IDX) ? LAST_IDX : wr_idx_d;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_addr
      localparam logic [ADDR_W-1:0] CH_OFS = (INTERLEAVE == INTERLEAVED)
                                           ? ADDR_W'(BASE + c)
                                           : ADDR_W'(BASE + c * CH_DEPTH);
      logic [ADDR_W-1:0] idx_term;
      if (INTERLEAVE == INTERLEAVED) begin : g_interleaved
        assign idx_term = ADDR_W'(addr_idx) * ADDR_W'(CHANNELS);
      end else begin : g_banked
        assign idx_term = ADDR_W'(addr_idx);
      end
      assign idx_addr[c*ADDR_W +: ADDR_W] = CH_OFS + idx_term;
    end
  endgenerate

  // The address register follows the index only when the index moves, so it
  // keeps its reset value of zero until the first start.
  always_comb begin
    wr_addr_d = wr_addr_q;
    if (start_ok || wr_en) begin
      wr_addr_d = idx_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      wr_idx_q  <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      wr_idx_q  <= wr_idx_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign wr_addr = wr_addr_q;
  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_pool_mem_write.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pool_mem_write
//  Description : Self-checking bench for pool_mem_write. Two instances: the
//                default banked configuration and a 4-channel interleaved
//                one. Expected writes are queued at accept time and matched
//                when wr_en appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_mem_write;

  localparam int P_CH   [2] = '{2, 4};
  localparam int P_DEP  [2] = '{72, 16};
  localparam int P_BASE [2] = '{0, 8};
  localparam int P_PD   [2] = '{1, 3};
  localparam int P_IL   [2] = '{0, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_start, s0_valid, r0_ready, w0_en, b0_busy, d0_done;
  logic [15:0] a0;
  logic        s1_start, s1_valid, r1_ready, w1_en, b1_busy, d1_done;
  logic [31:0] a1;

  always #5 clk = ~clk;

  pool_mem_write dut0 (
    .clk      (clk),
    .reset    (rst_n),
    .start    (s0_start),
    .in_valid (s0_valid),
    .in_ready (r0_ready),
    .wr_en    (w0_en),
    .wr_addr  (a0),
    .busy     (b0_busy),
    .done     (d0_done)
  );

  pool_mem_write #(
    .ADDR_W     (8),
    .CHANNELS   (4),
    .CH_DEPTH   (16),
    .BASE       (8),
    .PIPE_DELAY (3),
    .INTERLEAVE (1)
  ) dut1 (
    .clk      (clk),
    .reset    (rst_n),
    .start    (s1_start),
    .in_valid (s1_valid),
    .in_ready (r1_ready),
    .wr_en    (w1_en),
    .wr_addr  (a1),
    .busy     (b1_busy),
    .done     (d1_done)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
  } sb_t;

  typedef struct {
    int          dut;
    int          gap;
    int          n_valid;
    int          exp_writes;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  sb_t         q0[$];
  sb_t         q1[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          m_acc  [2];
  int          m_wr   [2];
  bit          m_busy [2];
  bit          m_done [2];
  logic [31:0] m_first[2];
  logic [31:0] m_last [2];
  vec_t        vecs   [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_vec(input int d, input int idx);
    logic [31:0] v;
    int          a;
    v = '0;
    for (int c = 0; c < P_CH[d]; c++) begin
      if (P_IL[d] != 0) a = P_BASE[d] + idx * P_CH[d] + c;
      else              a = P_BASE[d] + c * P_DEP[d] + idx;
      v[c*8 +: 8] = a[7:0];
    end
    return v;
  endfunction

  task automatic model_clear(input int d);
    m_acc[d]   = 0;
    m_wr[d]    = 0;
    m_busy[d]  = 1'b0;
    m_done[d]  = 1'b0;
    m_first[d] = '0;
    m_last[d]  = '0;
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  // Compares the current cycle's outputs with the model, then advances the
  // model with the inputs about to be sampled on the next rising edge.
  task automatic monitor(input int d);
    logic        rdy, en, bsy, dn, st, vl;
    logic [31:0] addr;
    sb_t         e;
    int          qn;
    if (d == 0) begin
      rdy = r0_ready; en = w0_en; bsy = b0_busy; dn = d0_done;
      st = s0_start; vl = s0_valid; addr = {16'h0, a0}; qn = q0.size();
    end else begin
      rdy = r1_ready; en = w1_en; bsy = b1_busy; dn = d1_done;
      st = s1_start; vl = s1_valid; addr = a1; qn = q1.size();
    end
    if (!rst_n) begin
      model_clear(d);
      return;
    end
    chk($sformatf("busy%0d", d), bsy, m_busy[d]);
    chk($sformatf("done%0d", d), dn, m_done[d]);
    chk($sformatf("in_ready%0d", d), rdy, m_busy[d] && (m_acc[d] < P_DEP[d]));
    if (en) begin
      if (qn == 0) begin
        chk($sformatf("wr_en_unexpected%0d", d), en, 1'b0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("wr_time%0d", d), cyc, e.due);
        chk($sformatf("wr_addr%0d", d), addr, e.addr);
      end
      if (m_wr[d] == 0) m_first[d] = addr;
      m_last[d] = addr;
      m_wr[d]++;
      if (m_wr[d] == P_DEP[d]) begin
        m_busy[d] = 1'b0;
        m_done[d] = 1'b1;
      end
    end
    if (vl && m_busy[d] && m_acc[d] < P_DEP[d]) begin
      e.due  = cyc + P_PD[d];
      e.addr = exp_vec(d, m_acc[d]);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      m_acc[d]++;
    end
    if (st && !m_busy[d]) begin
      model_clear(d);
      m_busy[d] = 1'b1;
    end
  endtask

  // Drive one cycle of inputs to DUT d (the other DUT sits idle).
  task automatic tick(input int d, input bit vl, input bit st);
    s0_valid = (d == 0) && vl;
    s0_start = (d == 0) && st;
    s1_valid = (d == 1) && vl;
    s1_start = (d == 1) && st;
    monitor(0);
    monitor(1);
    @(negedge clk);
    cyc++;
  endtask

  task automatic finish_pass(input int d, input int exp_writes,
                             input logic [31:0] exp_first, input logic [31:0] exp_last);
    int n;
    n = 0;
    while (!m_done[d] && n < 400) begin
      tick(d, 1'b0, 1'b0);
      n++;
    end
    tick(d, 1'b0, 1'b0);
    chk("done_level", (d == 0) ? d0_done : d1_done, 1'b1);
    chk("n_writes", m_wr[d], exp_writes);
    chk("first_addr", m_first[d], exp_first);
    chk("last_addr", m_last[d], exp_last);
  endtask

  task automatic run_pass(input vec_t v);
    tick(v.dut, 1'b0, 1'b1);
    for (int i = 0; i < v.n_valid; i++) begin
      tick(v.dut, 1'b1, 1'b0);
      for (int g = 0; g < v.gap; g++) tick(v.dut, 1'b0, 1'b0);
    end
    finish_pass(v.dut, v.exp_writes, v.exp_first, v.exp_last);
  endtask

  initial begin
    int n;
    // addr1 in bits [15:8], addr0 in [7:0]; interleaved channel c in [c*8 +: 8]
    vecs[0] = '{dut: 0, gap: 0, n_valid: 72, exp_writes: 72, exp_first: 32'h0000_4800, exp_last: 32'h0000_8F47};
    vecs[1] = '{dut: 0, gap: 2, n_valid: 72, exp_writes: 72, exp_first: 32'h0000_4800, exp_last: 32'h0000_8F47};
    vecs[2] = '{dut: 0, gap: 0, n_valid: 80, exp_writes: 72, exp_first: 32'h0000_4800, exp_last: 32'h0000_8F47};
    vecs[3] = '{dut: 1, gap: 0, n_valid: 16, exp_writes: 16, exp_first: 32'h0B0A_0908, exp_last: 32'h4746_4544};
    vecs[4] = '{dut: 1, gap: 1, n_valid: 16, exp_writes: 16, exp_first: 32'h0B0A_0908, exp_last: 32'h4746_4544};

    rst_n = 1'b0;
    s0_start = 1'b0; s0_valid = 1'b0;
    s1_start = 1'b0; s1_valid = 1'b0;
    model_clear(0);
    model_clear(1);

    // Reset state
    @(negedge clk);
    chk("rst_ready0", r0_ready, 1'b0);
    chk("rst_wr_en0", w0_en, 1'b0);
    chk("rst_busy0", b0_busy, 1'b0);
    chk("rst_done0", d0_done, 1'b0);
    chk("rst_addr0", a0, 16'h0);
    chk("rst_ready1", r1_ready, 1'b0);
    chk("rst_wr_en1", w1_en, 1'b0);
    chk("rst_busy1", b1_busy, 1'b0);
    chk("rst_done1", d1_done, 1'b0);
    chk("rst_addr1", a1, 32'h0);
    tick(0, 1'b0, 1'b0);
    rst_n = 1'b1;
    // in_valid without start must do nothing
    for (int i = 0; i < 4; i++) tick(0, 1'b1, 1'b0);

    // Table-driven passes
    for (int k = 0; k < 5; k++) run_pass(vecs[k]);

    // start pulsed in RUN at accept 10 is ignored
    tick(0, 1'b0, 1'b1);
    for (int i = 0; i < 72; i++) tick(0, 1'b1, i == 10);
    finish_pass(0, 72, 32'h0000_4800, 32'h0000_8F47);

    // Reset in the middle of a pass, between clock edges
    tick(0, 1'b0, 1'b1);
    n = 0;
    while (m_wr[0] < 30 && n < 200) begin
      tick(0, 1'b1, 1'b0);
      n++;
    end
    chk("wr_before_reset", m_wr[0], 30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_wr_en", w0_en, 1'b0);
    chk("async_ready", r0_ready, 1'b0);
    chk("async_busy", b0_busy, 1'b0);
    chk("async_done", d0_done, 1'b0);
    chk("async_addr", a0, 16'h0);
    tick(0, 1'b1, 1'b0);
    tick(0, 1'b1, 1'b0);
    rst_n = 1'b1;
    // No writes or accepts until the next start
    for (int i = 0; i < 10; i++) tick(0, 1'b1, 1'b0);

    // Full recovery pass after reset
    run_pass(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
